eth_img_pkt_sched: RTL

- Multi-channel UDP packet scheduler in the eth_tx_clk domain, downstream of per-channel async image FIFOs (read side) and upstream of the UDP transmitter.
- Arbitrates round-robin among NUM_CH channels and inserts a per-packet header (channel, flags, sequence) plus an optional frame header.
- Drives the UDP start/byte-count/data handshake and enforces a parametrised inter-packet gap.
- Replaces single-stream packetizing with fixed-size, channel-tagged packets.

---
 rtl/eth_img_pkg.sv | 35 +++
 rtl/eth_rr_arbiter.sv | 45 ++++
 rtl/eth_img_pkt_sched.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/eth_img_pkg.sv
// Shared types and helpers for the channel-tagged image packet scheduler.
package eth_img_pkg;

    localparam logic [31:0] FRAME_HEAD_DEF = 32'hf05aa50f;

    // Per-packet header word layout: {4'h0, ch[3:0], 7'h0, first, seq[15:0]}
    localparam int unsigned CH_LSB    = 24;
    localparam int unsigned FIRST_BIT = 16;
    localparam int unsigned SEQ_LSB   = 0;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StStart,
        StSend,
        StGap
    } sched_state_e;

    function automatic logic [15:0] pkt_bytes(input logic first, input int unsigned pkt_words);
        int unsigned hdr;
        hdr = first ? 3 : 1;
        return 16'(4 * (hdr + pkt_words));
    endfunction

    function automatic logic [31:0] pkt_word0(input logic [3:0] ch, input logic first,
                                              input logic [15:0] seq);
        logic [31:0] w;
        w = '0;
        w[CH_LSB +: 4]   = ch;
        w[FIRST_BIT]     = first;
        w[SEQ_LSB +: 16] = seq;
        return w;
    endfunction

endpackage

// File: rtl/eth_rr_arbiter.sv
// Round-robin picker: first requester after the last granted index, wrapping.
module eth_rr_arbiter #(
    parameter int unsigned NUM_CH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic              grant_valid,
    output logic [3:0]        grant_idx
);

    logic [3:0] last_grant;
    logic       found_hi, found_lo;
    logic [3:0] idx_hi, idx_lo;

    // Descending scans leave the lowest matching index above / at-or-below the pointer.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i] && (4'(i) > last_grant)) begin
                found_hi = 1'b1;
                idx_hi   = 4'(i);
            end
            if (req[i] && (4'(i) <= last_grant)) begin
                found_lo = 1'b1;
                idx_lo   = 4'(i);
            end
        end
        grant_valid = found_hi | found_lo;
        grant_idx   = found_hi ? idx_hi : idx_lo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 4'(NUM_CH - 1);
        end else if (advance) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/eth_img_pkt_sched.sv
// Round-robin multi-channel UDP packet scheduler with per-packet and frame headers.
module eth_img_pkt_sched
    import eth_img_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned LEVEL_W    = 11,
    parameter int unsigned PKT_WORDS  = 240,
    parameter int unsigned IFG_CYCLES = 800,
    parameter logic [15:0] H_PIXEL    = 16'd960,
    parameter logic [15:0] V_PIXEL    = 16'd540,
    parameter logic [31:0] FRAME_HEAD = FRAME_HEAD_DEF
) (
    input  logic                      eth_tx_clk,
    input  logic                      eth_rst,
    input  logic                      transfer_flag,
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic [NUM_CH-1:0]         ch_frame_start,
    input  logic [NUM_CH*LEVEL_W-1:0] ch_rd_level,
    input  logic [NUM_CH*32-1:0]      ch_rd_data,
    output logic [NUM_CH-1:0]         ch_rd_en,
    input  logic                      udp_tx_req,
    input  logic                      udp_tx_done,
    output logic                      udp_tx_start_en,
    output logic [15:0]               udp_tx_byte_num,
    output logic [31:0]               udp_tx_data,
    output logic [3:0]                cur_ch,
    output logic                      err_overrun
);

    sched_state_e      state;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] pending_first;
    logic [15:0]       seq [NUM_CH];
    logic              grant_valid, grant_take, grant_first;
    logic [3:0]        grant_idx;
    logic [15:0]       grant_seq;
    logic              first;
    logic [15:0]       seq_cur, hdr_len, word_cnt;
    logic [31:0]       gap_cnt, hdr_word, hdr_data, rd_word;
    logic              sel_payload, in_hdr, in_payload;

    always_comb begin
        eligible    = '0;
        grant_first = 1'b0;
        grant_seq   = '0;
        rd_word     = '0;
        ch_rd_en    = '0;
        in_hdr      = word_cnt < hdr_len;
        in_payload  = !in_hdr && (word_cnt < hdr_len + 16'(PKT_WORDS));
        for (int i = 0; i < NUM_CH; i++) begin
            eligible[i] = ch_enable[i] && (32'(ch_rd_level[i*LEVEL_W +: LEVEL_W]) >= PKT_WORDS);
            if (grant_idx == 4'(i)) begin
                grant_first = pending_first[i];
                grant_seq   = seq[i];
            end
            if (cur_ch == 4'(i)) begin
                rd_word     = ch_rd_data[i*32 +: 32];
                ch_rd_en[i] = (state == StSend) && udp_tx_req && in_payload;
            end
        end
        if (word_cnt == 16'd0) begin
            hdr_word = pkt_word0(cur_ch, first, seq_cur);
        end else if (word_cnt == 16'd1) begin
            hdr_word = FRAME_HEAD;
        end else begin
            hdr_word = {H_PIXEL, V_PIXEL};
        end
    end

    assign grant_take  = (state == StArb) && transfer_flag && grant_valid;
    // FIFO data has one cycle of read latency, so payload words bypass the output register.
    assign udp_tx_data = sel_payload ? rd_word : hdr_data;

    eth_rr_arbiter #(
        .NUM_CH(NUM_CH)
    ) u_arb (
        .clk        (eth_tx_clk),
        .rst        (eth_rst),
        .req        (eligible),
        .advance    (grant_take),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx)
    );

    always_ff @(posedge eth_tx_clk or posedge eth_rst) begin
        if (eth_rst) begin
            state           <= StIdle;
            cur_ch          <= '0;
            first           <= 1'b0;
            seq_cur         <= '0;
            hdr_len         <= '0;
            word_cnt        <= '0;
            gap_cnt         <= '0;
            udp_tx_byte_num <= '0;
            udp_tx_start_en <= 1'b0;
            err_overrun     <= 1'b0;
            sel_payload     <= 1'b0;
            hdr_data        <= '0;
        end else begin
            udp_tx_start_en <= 1'b0;
            sel_payload     <= 1'b0;
            hdr_data        <= '0;
            if (udp_tx_req && (state != StSend)) begin
                err_overrun <= 1'b1;
            end
            unique case (state)
                StIdle: begin
                    if (transfer_flag) state <= StArb;
                end
                StArb: begin
                    if (!transfer_flag) begin
                        state <= StIdle;
                    end else if (grant_valid) begin
                        cur_ch          <= grant_idx;
                        first           <= grant_first;
                        seq_cur         <= grant_seq;
                        hdr_len         <= grant_first ? 16'd3 : 16'd1;
                        udp_tx_byte_num <= pkt_bytes(grant_first, PKT_WORDS);
                        udp_tx_start_en <= 1'b1;
                        state           <= StStart;
                    end
                end
                StStart: begin
                    word_cnt <= '0;
                    state    <= StSend;
                end
                StSend: begin
                    if (udp_tx_req) begin
                        if (word_cnt != '1) word_cnt <= word_cnt + 16'd1;
                        if (in_hdr) begin
                            hdr_data <= hdr_word;
                        end else if (in_payload) begin
                            sel_payload <= 1'b1;
                        end else begin
                            err_overrun <= 1'b1;
                        end
                    end
                    if (udp_tx_done) begin
                        gap_cnt <= IFG_CYCLES;
                        state   <= StGap;
                    end
                end
                StGap: begin
                    if (gap_cnt == '0) begin
                        state <= StArb;
                    end else begin
                        gap_cnt <= gap_cnt - 32'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // A frame start wins over a coincident grant: the granted packet keeps the old state.
    always_ff @(posedge eth_tx_clk or posedge eth_rst) begin
        if (eth_rst) begin
            pending_first <= '0;
            for (int i = 0; i < NUM_CH; i++) seq[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_frame_start[i]) begin
                    pending_first[i] <= 1'b1;
                    seq[i]           <= '0;
                end else if (grant_take && (grant_idx == 4'(i))) begin
                    pending_first[i] <= 1'b0;
                    seq[i]           <= seq[i] + 16'd1;
                end
            end
        end
    end

endmodule
